rupt_priority_chain: RTL



---
 rtl/agc_rupt_pkg.sv | 43 ++++
 rtl/rupt_prio_enc.sv | 20 ++
 rtl/rupt_priority_chain.sv | 123 ++++++++++++
 3 files changed

// File: rtl/agc_rupt_pkg.sv
// Shared definitions for the rupt priority chain: FSM states, source
// numbering, vector address defaults and the vector-to-address mapping.
package agc_rupt_pkg;

    // Number of rupt sources the chain and encoder are built for
    localparam int RUPT_NSRC = 10;

    // Vector numbers of each source, 1 is the highest priority
    localparam int RPT_T6  = 1;
    localparam int RPT_T5  = 2;
    localparam int RPT_T3  = 3;
    localparam int RPT_T4  = 4;
    localparam int RPT_KY1 = 5;
    localparam int RPT_KY2 = 6;
    localparam int RPT_UP  = 7;
    localparam int RPT_DN  = 8;
    localparam int RPT_RAD = 9;
    localparam int RPT_HND = 10;

    // Default vector table placement
    localparam logic [11:0] RUPT_VBASE_DEF = 12'o4000;
    localparam int unsigned RUPT_VSTEP_DEF = 4;

    // Rupt chain sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } rupt_state_e;

    // Vector number to service address; vector 0 means "no request" and maps to 0
    function automatic logic [11:0] ruptVecAddr(input logic [3:0] vec,
                                                input logic [11:0] base,
                                                input int unsigned step);
        logic [11:0] offset;
        offset = 12'(step * 32'(vec));
        if (vec == 4'd0) begin
            return 12'd0;
        end
        return base + offset;
    endfunction

endpackage

// File: rtl/rupt_prio_enc.sv
// Lowest-index-wins priority encoder: returns the 1-based number of the
// lowest set request bit, or 0 when no bit is set.
module rupt_prio_enc
    import agc_rupt_pkg::*;
(
    input  logic [RUPT_NSRC-1:0] req_i,
    output logic [3:0]           vec_o
);

    // Scan from the lowest priority upward so the lowest set index is left standing
    always_comb begin
        vec_o = 4'd0;
        for (int i = RUPT_NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vec_o = 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/rupt_priority_chain.sv
// Rupt request latches and priority chain. Sources set pending latches; when
// rupts are permitted the highest-priority pending source is frozen into a
// vector, offered over RPTREQ/RPTGNT, and further rupts are held off until
// the service routine signals RESUME.
module rupt_priority_chain
    import agc_rupt_pkg::*;
#(
    parameter int          NSRC  = RUPT_NSRC,
    parameter logic [11:0] VBASE = RUPT_VBASE_DEF,
    parameter int unsigned VSTEP = RUPT_VSTEP_DEF
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            GOJAM,
    input  logic            T6RUPT,
    input  logic            T5RUPT,
    input  logic            T3RUPT,
    input  logic            T4RUPT,
    input  logic            KYRPT1,
    input  logic            KYRPT2,
    input  logic            UPRUPT,
    input  logic            DNRUPT,
    input  logic            RADRPT,
    input  logic            HNDRPT,
    input  logic            INHINT,
    input  logic            OVFINH,
    input  logic            RPTGNT,
    input  logic            RESUME,
    output logic            RPTREQ,
    output logic [3:0]      RPTVEC,
    output logic [11:0]     RPTADR,
    output logic            INRUPT,
    output logic [NSRC-1:0] PEND
);

    rupt_state_e     state_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] pend_d;
    logic [NSRC-1:0] srcVec;
    logic [NSRC-1:0] pendClr;
    logic [3:0]      vec_q;
    logic [11:0]     adr_q;
    logic            req_q;
    logic            inrupt_q;
    logic [3:0]      encVec;
    logic            grantNow;

    assign srcVec[RPT_T6-1]  = T6RUPT;
    assign srcVec[RPT_T5-1]  = T5RUPT;
    assign srcVec[RPT_T3-1]  = T3RUPT;
    assign srcVec[RPT_T4-1]  = T4RUPT;
    assign srcVec[RPT_KY1-1] = KYRPT1;
    assign srcVec[RPT_KY2-1] = KYRPT2;
    assign srcVec[RPT_UP-1]  = UPRUPT;
    assign srcVec[RPT_DN-1]  = DNRUPT;
    assign srcVec[RPT_RAD-1] = RADRPT;
    assign srcVec[RPT_HND-1] = HNDRPT;

    assign grantNow = (state_q == REQ) && RPTGNT;

    rupt_prio_enc u_prio_enc (
        .req_i (pend_q),
        .vec_o (encVec)
    );

    // Next pending state: granted latch clears, but a simultaneous set wins
    always_comb begin
        pendClr = '0;
        for (int k = 0; k < NSRC; k++) begin
            pendClr[k] = grantNow && (vec_q == 4'(k + 1));
        end
        pend_d = (pend_q & ~pendClr) | srcVec;
    end

    // Chain sequencer with registered request, vector, address and service flag
    always_ff @(posedge CLOCK) begin
        if (rst || GOJAM) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            req_q    <= 1'b0;
            vec_q    <= 4'd0;
            adr_q    <= 12'd0;
            inrupt_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if ((pend_q != '0) && !INHINT && !OVFINH) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        vec_q   <= encVec;
                        adr_q   <= ruptVecAddr(encVec, VBASE, VSTEP);
                    end
                end
                REQ: begin
                    if (RPTGNT) begin
                        state_q  <= SERV;
                        req_q    <= 1'b0;
                        vec_q    <= 4'd0;
                        adr_q    <= 12'd0;
                        inrupt_q <= 1'b1;
                    end
                end
                SERV: begin
                    if (RESUME) begin
                        state_q  <= IDLE;
                        inrupt_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign RPTREQ = req_q;
    assign RPTVEC = vec_q;
    assign RPTADR = adr_q;
    assign INRUPT = inrupt_q;
    assign PEND   = pend_q;

endmodule
